// File: rtl/dac_spi_monitor.sv
// dac_spi_monitor: receive-side AD5541A model with per-channel input/DAC registers and frame checking
module dac_spi_monitor #(
    parameter int NCH       = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk_50,
    input  logic                 reset_n,
    input  logic                 DAC_SCK,
    input  logic [NCH-1:0]       DAC_CS_N,
    input  logic [NCH-1:0]       DAC_SDO,
    input  logic                 DAC_LDAC_N,
    output logic [NCH-1:0]       word_valid,
    output logic [NCH-1:0]       frame_err,
    output logic                 dac_update,
    output logic [16*NCH-1:0]    dac_code,
    output logic [16*NCH-1:0]    dac_signed,
    output logic [ERR_CNT_W-1:0] err_count
);
    logic                        sck_r1_q, sck_r2_q, ldac_r1_q, ldac_r2_q;
    logic [NCH-1:0]              cs_r1_q, cs_r2_q, sdo_r1_q;
    logic [NCH-1:0][15:0]        shift_q, shift_d, in_q, in_d, code_q, code_d, sgn_q;
    logic [NCH-1:0][4:0]         cnt_q, cnt_d;
    logic [NCH-1:0]              pend_q, pend_d, wv_q, wv_d, fe_q, fe_d;
    logic                        upd_q;
    logic [ERR_CNT_W-1:0]        err_q, err_d;
    logic [ERR_CNT_W:0]          err_sum;
    logic                        sck_rise, ldac_fall;
    logic [NCH-1:0]              cs_fall, cs_rise, shift_en;

    assign sck_rise  = sck_r1_q & ~sck_r2_q;
    assign ldac_fall = ~ldac_r1_q & ldac_r2_q;
    assign cs_fall   = ~cs_r1_q & cs_r2_q;
    assign cs_rise   = cs_r1_q & ~cs_r2_q;
    assign shift_en  = {NCH{sck_rise}} & ~cs_r1_q;

    // Per-channel deserializer, frame check, input/DAC register transfer and error accounting
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        pend_d  = pend_q;
        code_d  = code_q;
        wv_d    = '0;
        fe_d    = '0;
        err_sum = {1'b0, err_q};
        for (int i = 0; i < NCH; i++) begin
            if (shift_en[i]) shift_d[i] = {shift_q[i][14:0], sdo_r1_q[i]};
            cnt_d[i] = cs_fall[i] ? {4'd0, shift_en[i]} :
                       (shift_en[i] && cnt_q[i] != 5'd31) ? cnt_q[i] + 5'd1 : cnt_q[i];
            wv_d[i] = cs_rise[i] && cnt_q[i] == 5'd16;
            fe_d[i] = cs_rise[i] && cnt_q[i] != 5'd16;
            if (wv_d[i]) in_d[i] = shift_q[i];
            pend_d[i] = ldac_fall ? 1'b0 : (pend_q[i] | wv_d[i]);
            // A word completing in the LDAC cycle bypasses the input register
            if (ldac_fall && (wv_d[i] || pend_q[i])) code_d[i] = wv_d[i] ? shift_q[i] : in_q[i];
            err_sum = err_sum + {{ERR_CNT_W{1'b0}}, fe_d[i]};
        end
        err_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end

    // Line sampling, edge-detect history and all architectural state
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            sck_r1_q  <= 1'b0;
            sck_r2_q  <= 1'b0;
            ldac_r1_q <= 1'b1;
            ldac_r2_q <= 1'b1;
            cs_r1_q   <= '1;
            cs_r2_q   <= '1;
            sdo_r1_q  <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            in_q      <= {NCH{16'h8000}};
            pend_q    <= '0;
            code_q    <= {NCH{16'h8000}};
            sgn_q     <= '0;
            wv_q      <= '0;
            fe_q      <= '0;
            upd_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            sck_r1_q  <= DAC_SCK;
            sck_r2_q  <= sck_r1_q;
            ldac_r1_q <= DAC_LDAC_N;
            ldac_r2_q <= ldac_r1_q;
            cs_r1_q   <= DAC_CS_N;
            cs_r2_q   <= cs_r1_q;
            sdo_r1_q  <= DAC_SDO;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            in_q      <= in_d;
            pend_q    <= pend_d;
            code_q    <= code_d;
            sgn_q     <= code_d ^ {NCH{16'h8000}};
            wv_q      <= wv_d;
            fe_q      <= fe_d;
            upd_q     <= ldac_fall;
            err_q     <= err_d;
        end
    end

    assign word_valid = wv_q;
    assign frame_err  = fe_q;
    assign dac_update = upd_q;
    assign dac_code   = code_q;
    assign dac_signed = sgn_q;
    assign err_count  = err_q;
endmodule
